// File: rtl/sr04_pkg.sv
// sr04_pkg: shared types, FSM states and source codes for the SR04 controller.
// No ports; imported by the interface, the averaging filter and the top.
package sr04_pkg;

    localparam int MAX_CM = 400;
    localparam int TMR_W  = 17;

    typedef logic [$clog2(MAX_CM + 1) - 1:0] dist_t;
    typedef logic [TMR_W - 1:0]              tmr_t;

    localparam logic [1:0] SRC_AUTO = 2'd0;
    localparam logic [1:0] SRC_UART = 2'd1;
    localparam logic [1:0] SRC_BTN  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_RESULT  = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_e;

endpackage

// File: rtl/sr04_meas_ctrl_if.sv
// sr04_meas_ctrl_if: counter-unit handshake plus published result bus.
// master = controller (drives start/clear/results), slave = counter unit / consumer.
interface sr04_meas_ctrl_if;
    import sr04_pkg::*;

    logic       cnt_start;
    logic       cnt_clear;
    logic       cnt_done;
    dist_t      cnt_distance;
    logic       busy;
    dist_t      dist_raw;
    dist_t      dist_avg;
    logic       dist_valid;
    logic [1:0] dist_src;
    logic       timeout_err;

    modport master (
        output cnt_start, cnt_clear, busy,
        output dist_raw, dist_avg, dist_valid, dist_src, timeout_err,
        input  cnt_done, cnt_distance
    );

    modport slave (
        input  cnt_start, cnt_clear, busy,
        input  dist_raw, dist_avg, dist_valid, dist_src, timeout_err,
        output cnt_done, cnt_distance
    );

endinterface

// File: rtl/sr04_avg_filter.sv
// sr04_avg_filter: 2^AVG_LOG2-deep shift buffer with running sum.
// Ports: clk, reset, push + sample in; registered dist_raw / dist_avg out.
module sr04_avg_filter
    import sr04_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  dist_t sample,
    output dist_t dist_raw,
    output dist_t dist_avg
);

    localparam int WIN = 1 << AVG_LOG2;
    localparam int SW  = $bits(dist_t) + AVG_LOG2;
    localparam int FW  = AVG_LOG2 + 1;

    dist_t         buf_q [WIN];
    logic [SW-1:0] sum;
    logic [SW-1:0] sum_n;
    logic [FW-1:0] fill;
    logic          full_n;

    // Buffer starts zeroed, so subtracting the oldest slot is
    // harmless while the window is still filling.
    assign sum_n  = sum + SW'(sample) - SW'(buf_q[WIN-1]);
    assign full_n = (fill >= FW'(WIN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIN; i++) begin
                buf_q[i] <= '0;
            end
            sum      <= '0;
            fill     <= '0;
            dist_raw <= '0;
            dist_avg <= '0;
        end else if (push) begin
            buf_q[0] <= sample;
            for (int i = 1; i < WIN; i++) begin
                buf_q[i] <= buf_q[i-1];
            end
            sum      <= sum_n;
            if (fill != FW'(WIN)) begin
                fill <= fill + FW'(1);
            end
            dist_raw <= sample;
            dist_avg <= full_n ? dist_t'(sum_n >> AVG_LOG2) : sample;
        end
    end

endmodule

// File: rtl/sr04_meas_ctrl.sv
// sr04_meas_ctrl: sequences SR04 measurements from uart/button/auto requests.
// Ports: clk, reset, tick_1us, auto_en, req_uart, req_btn; bus = counter + result.
module sr04_meas_ctrl
    import sr04_pkg::*;
#(
    parameter int PERIOD_US  = 100000,
    parameter int TIMEOUT_US = 30000,
    parameter int MIN_GAP_US = 60000,
    parameter int AVG_LOG2   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_1us,
    input  logic auto_en,
    input  logic req_uart,
    input  logic req_btn,
    sr04_meas_ctrl_if.master bus
);

    localparam tmr_t PER_M1 = tmr_t'(PERIOD_US - 1);
    localparam tmr_t TO_M1  = tmr_t'(TIMEOUT_US - 1);
    localparam tmr_t GAP_M1 = tmr_t'(MIN_GAP_US - 1);

    state_e     state;
    state_e     state_n;
    tmr_t       step_tmr;
    tmr_t       step_tmr_n;
    tmr_t       auto_tmr;
    logic       pend_u;
    logic       pend_b;
    logic       pend_a;
    logic       rr;
    logic [1:0] src;
    logic [1:0] src_n;
    logic [1:0] src_g;
    dist_t      sample;
    logic       in_idle;
    logic       gnt_u;
    logic       gnt_b;
    logic       gnt_a;
    logic       auto_hit;
    logic       start_n;
    logic       clear_n;
    logic       push;

    assign in_idle  = (state == ST_IDLE);
    assign auto_hit = auto_en & tick_1us & (auto_tmr == PER_M1);

    // rr=0 favours uart when both manual requests are pending.
    assign gnt_u = in_idle & pend_u & (~pend_b | ~rr);
    assign gnt_b = in_idle & pend_b & (~pend_u | rr);
    assign gnt_a = in_idle & pend_a & ~pend_u & ~pend_b;

    always_comb begin
        src_g = SRC_AUTO;
        unique case (1'b1)
            gnt_u:   src_g = SRC_UART;
            gnt_b:   src_g = SRC_BTN;
            default: src_g = SRC_AUTO;
        endcase
    end

    always_comb begin
        state_n    = state;
        step_tmr_n = step_tmr;
        src_n      = src;
        start_n    = 1'b0;
        clear_n    = 1'b0;
        push       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pend_u | pend_b | pend_a) begin
                    state_n = ST_GRANT;
                    src_n   = src_g;
                    start_n = 1'b1;
                end
            end
            ST_GRANT: begin
                step_tmr_n = '0;
                state_n    = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (bus.cnt_done) begin
                    state_n = ST_RESULT;
                end else if (tick_1us) begin
                    if (step_tmr == TO_M1) begin
                        clear_n    = 1'b1;
                        step_tmr_n = '0;
                        state_n    = ST_HOLDOFF;
                    end else begin
                        step_tmr_n = step_tmr + tmr_t'(1);
                    end
                end
            end
            ST_RESULT: begin
                push       = 1'b1;
                step_tmr_n = '0;
                state_n    = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (tick_1us) begin
                    if (step_tmr == GAP_M1) begin
                        state_n = ST_IDLE;
                    end else begin
                        step_tmr_n = step_tmr + tmr_t'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            step_tmr        <= '0;
            auto_tmr        <= '0;
            pend_u          <= 1'b0;
            pend_b          <= 1'b0;
            pend_a          <= 1'b0;
            rr              <= 1'b0;
            src             <= SRC_AUTO;
            sample          <= '0;
            bus.cnt_start   <= 1'b0;
            bus.cnt_clear   <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.busy        <= 1'b0;
            bus.dist_valid  <= 1'b0;
            bus.dist_src    <= SRC_AUTO;
        end else begin
            state    <= state_n;
            step_tmr <= step_tmr_n;
            src      <= src_n;
            // A request arriving on its own grant cycle is served by that grant.
            pend_u   <= (pend_u | req_uart) & ~gnt_u;
            pend_b   <= (pend_b | req_btn) & ~gnt_b;
            pend_a   <= auto_en & (pend_a | auto_hit) & ~gnt_a;
            if (!auto_en) begin
                auto_tmr <= '0;
            end else if (tick_1us) begin
                auto_tmr <= auto_hit ? '0 : auto_tmr + tmr_t'(1);
            end
            if (gnt_u | gnt_b) begin
                rr <= ~rr;
            end
            if (state == ST_MEASURE && bus.cnt_done) begin
                sample <= bus.cnt_distance;
            end
            bus.cnt_start   <= start_n;
            bus.cnt_clear   <= clear_n;
            bus.timeout_err <= clear_n;
            bus.busy        <= (state_n != ST_IDLE);
            bus.dist_valid  <= push;
            if (push) begin
                bus.dist_src <= src;
            end
        end
    end

    sr04_avg_filter #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .sample   (sample),
        .dist_raw (bus.dist_raw),
        .dist_avg (bus.dist_avg)
    );

endmodule

// File: tb/tb_sr04_meas_ctrl.sv
// tb_sr04_meas_ctrl: directed stimulus with a transaction-level model
// of the counter unit, arbitration order, holdoff and averaging.
module tb_sr04_meas_ctrl;

    localparam int PER = 1000;
    localparam int TO  = 300;
    localparam int GAP = 100;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic tick_1us = 1'b0;
    logic auto_en  = 1'b0;
    logic req_uart = 1'b0;
    logic req_btn  = 1'b0;

    sr04_meas_ctrl_if bus ();

    sr04_meas_ctrl #(
        .PERIOD_US  (PER),
        .TIMEOUT_US (TO),
        .MIN_GAP_US (GAP),
        .AVG_LOG2   (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick_1us (tick_1us),
        .auto_en  (auto_en),
        .req_uart (req_uart),
        .req_btn  (req_btn),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int dly      = 200;
    int dist_q[$];
    int exp_src[$];
    int exp_raw[$];
    int hist[$];
    bit in_meas   = 0;
    bit done_pend = 0;
    bit holding   = 0;
    bit prev_busy = 0;
    bit stray     = 0;
    int meas_ticks = 0;
    int hold_ticks = 0;
    int done_cyc   = 0;
    int n_start = 0;
    int n_valid = 0;
    int n_to    = 0;
    int n_src0  = 0;

    task automatic chk(input bit ok, input string nm,
                       input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.cnt_start, bus.cnt_clear, bus.busy,
                     bus.dist_valid, bus.timeout_err, bus.dist_src,
                     bus.dist_raw, bus.dist_avg});
    endfunction

    // Sample at negedge, then drive the counter-unit model for the next edge.
    always @(negedge clk) begin
        bit st;
        int r;
        int e;
        int s;
        cyc++;
        st = 0;
        if (reset) begin
            chk(outs() == 0, "reset_outputs", outs(), 0);
            in_meas   = 0;
            done_pend = 0;
            holding   = 0;
            prev_busy = 0;
            hist.delete();
            exp_src.delete();
            exp_raw.delete();
        end else begin
            chk(bus.cnt_clear == bus.timeout_err, "clear_eq_timeout",
                bus.cnt_clear, bus.timeout_err);
            if (bus.cnt_start) begin
                chk(!prev_busy && bus.busy, "start_from_idle",
                    {prev_busy, bus.busy}, 1);
                n_start++;
                in_meas    = 1;
                meas_ticks = 0;
                st         = 1;
            end
            if (bus.timeout_err) begin
                chk(in_meas && meas_ticks == TO, "timeout_time",
                    meas_ticks, TO);
                in_meas    = 0;
                holding    = 1;
                hold_ticks = 0;
                n_to++;
            end
            if (bus.dist_valid) begin
                chk(done_pend && cyc == done_cyc + 2, "valid_latency",
                    cyc - done_cyc, 2);
                done_pend = 0;
                r = (exp_raw.size() > 0) ? exp_raw.pop_front() : -1;
                s = (exp_src.size() > 0) ? exp_src.pop_front() : -1;
                if (r >= 0) begin
                    hist.push_back(r);
                    if (hist.size() > 4) void'(hist.pop_front());
                end
                if (hist.size() < 4) e = r;
                else e = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
                chk(int'(bus.dist_raw) == r, "model_raw", bus.dist_raw, r);
                chk(int'(bus.dist_avg) == e, "model_avg", bus.dist_avg, e);
                chk(int'(bus.dist_src) == s, "model_src", bus.dist_src, s);
                if (bus.dist_src == 2'd0) n_src0++;
                n_valid++;
                holding    = 1;
                hold_ticks = 0;
            end
            if (holding && !bus.busy) begin
                chk(hold_ticks == GAP, "holdoff_len", hold_ticks, GAP);
                holding = 0;
            end
            prev_busy = bus.busy;
        end
        tick_1us = (cyc % 2 == 0);
        if (in_meas && !st && tick_1us) meas_ticks++;
        if (holding && tick_1us) hold_ticks++;
        bus.cnt_done = 1'b0;
        if (!reset && in_meas && !st && !done_pend && dly >= 0
            && meas_ticks >= dly) begin
            bus.cnt_done     = 1'b1;
            bus.cnt_distance = (dist_q.size() > 0) ?
                               9'(dist_q.pop_front()) : 9'd200;
            exp_raw.push_back(int'(bus.cnt_distance));
            done_pend = 1;
            done_cyc  = cyc;
            in_meas   = 0;
        end else if (stray) begin
            bus.cnt_done     = 1'b1;
            bus.cnt_distance = 9'd77;
            stray            = 0;
        end
    end

    task automatic pulse(input bit u, input bit b);
        @(posedge clk); #1;
        req_uart = u;
        req_btn  = b;
        @(posedge clk); #1;
        req_uart = 1'b0;
        req_btn  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        dist_q.delete();
    endtask

    task automatic wait_evt(input int target, input string nm);
        int k = 0;
        while (n_valid + n_to < target && k < 4000) begin
            @(posedge clk); #1;
            k++;
        end
        chk(n_valid + n_to >= target, nm, n_valid + n_to, target);
    endtask

    task automatic wait_quiet(input string nm);
        int q = 0;
        int k = 0;
        while (q < 4 && k < 4000) begin
            @(posedge clk); #1;
            k++;
            q = bus.busy ? 0 : q + 1;
        end
        chk(q >= 4, nm, q, 4);
    endtask

    initial begin
        int base;
        int ns;
        int nv;
        int smp[5];
        int avg[5];
        smp = '{100, 104, 108, 112, 116};
        avg = '{100, 104, 108, 106, 110};

        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk(outs() == 0, "post_reset_state", outs(), 0);

        // single uart request, 123 cm
        dist_q.push_back(123);
        exp_src.push_back(1);
        base = n_valid + n_to;
        pulse(1'b1, 1'b0);
        @(posedge clk); #1;
        chk(bus.cnt_start == 1'b1, "grant_to_start", bus.cnt_start, 1);
        chk(bus.busy == 1'b1, "busy_at_start", bus.busy, 1);
        wait_evt(base + 1, "t1_done");
        chk(bus.dist_raw == 9'd123, "t1_raw", bus.dist_raw, 123);
        chk(bus.dist_avg == 9'd123, "t1_avg", bus.dist_avg, 123);
        chk(bus.dist_src == 2'd1, "t1_src", bus.dist_src, 1);
        wait_quiet("t1_idle");

        // simultaneous pair after reset: uart then btn
        do_reset();
        exp_src.push_back(1);
        exp_src.push_back(2);
        dist_q.push_back(50);
        dist_q.push_back(60);
        ns   = n_start;
        base = n_valid + n_to;
        pulse(1'b1, 1'b1);
        wait_evt(base + 2, "pair1_done");
        wait_quiet("pair1_idle");
        chk(n_start - ns == 2, "pair1_starts", n_start - ns, 2);
        chk(bus.dist_src == 2'd2, "pair1_last_src", bus.dist_src, 2);

        // lone uart moves the pointer to btn
        exp_src.push_back(1);
        base = n_valid + n_to;
        pulse(1'b1, 1'b0);
        wait_evt(base + 1, "lone_uart_done");
        wait_quiet("lone_uart_idle");

        // next pair: btn first
        exp_src.push_back(2);
        exp_src.push_back(1);
        ns   = n_start;
        base = n_valid + n_to;
        pulse(1'b1, 1'b1);
        wait_evt(base + 2, "pair2_done");
        wait_quiet("pair2_idle");
        chk(n_start - ns == 2, "pair2_starts", n_start - ns, 2);
        chk(bus.dist_src == 2'd1, "pair2_last_src", bus.dist_src, 1);

        // counter never answers -> timeout, then a fresh request works
        dly  = -1;
        ns   = n_to;
        nv   = n_valid;
        base = n_valid + n_to;
        pulse(1'b0, 1'b1);
        wait_evt(base + 1, "timeout_seen");
        wait_quiet("timeout_idle");
        chk(n_to - ns == 1, "timeout_count", n_to - ns, 1);
        chk(n_valid == nv, "timeout_no_valid", n_valid - nv, 0);
        dly = 200;
        dist_q.push_back(90);
        exp_src.push_back(1);
        base = n_valid + n_to;
        pulse(1'b1, 1'b0);
        wait_evt(base + 1, "after_timeout_done");
        chk(bus.dist_raw == 9'd90, "after_timeout_raw", bus.dist_raw, 90);
        wait_quiet("after_timeout_idle");

        // averaging window fill and slide
        do_reset();
        for (int i = 0; i < 5; i++) begin
            dist_q.push_back(smp[i]);
            exp_src.push_back(1);
            base = n_valid + n_to;
            pulse(1'b1, 1'b0);
            wait_evt(base + 1, "avg_done");
            chk(int'(bus.dist_avg) == avg[i], "avg_literal",
                bus.dist_avg, avg[i]);
            wait_quiet("avg_idle");
        end

        // auto mode for 3500 us -> three auto measurements
        nv = n_src0;
        repeat (3) exp_src.push_back(0);
        @(posedge clk); #1;
        auto_en = 1'b1;
        repeat (3500 * 2) @(posedge clk);
        #1;
        auto_en = 1'b0;
        wait_quiet("auto_idle");
        chk(n_src0 - nv == 3, "auto_count", n_src0 - nv, 3);
        repeat (2000 * 2) @(posedge clk);
        #1;
        chk(n_src0 - nv == 3, "auto_off_none", n_src0 - nv, 3);

        // reset in the middle of a measurement
        dist_q.push_back(150);
        exp_src.push_back(1);
        pulse(1'b1, 1'b0);
        ns = 0;
        while (!in_meas && ns < 50) begin
            @(posedge clk); #1;
            ns++;
        end
        chk(in_meas, "mid_meas_reached", in_meas, 1);
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk(outs() == 0, "mid_reset_outputs", outs(), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        dist_q.delete();
        ns    = n_start;
        nv    = n_valid;
        stray = 1;
        repeat (1000) @(posedge clk);
        #1;
        chk(n_start == ns, "no_start_after_reset", n_start - ns, 0);
        chk(n_valid == nv, "late_done_ignored", n_valid - nv, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
